mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory bus between the core's instruction-fetch port and its data (memory-stage) port. One transaction is outstanding at a time. Data requests have priority, bounded by an anti-starvation counter that guarantees forward progress of fetch. Sits between the pipeline's fetch/memory stages and the external memory interface, inside the core wrapper.

## Interface
Parameters:
- `AW`, default 64: address width.
- `DW`, default 64: data width; strobe width is `DW/8`.
- `STARVE`, default 4: maximum consecutive data grants while fetch is waiting; range 1..15.

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  fetch request pending.
- `i_addr`  in  AW  fetch address.
- `i_ready`  out  1  fetch completion pulse; `i_data` is valid in the same cycle.
- `i_data`  out  DW  fetch read data.
- `d_valid`  in  1  data request pending.
- `d_addr`  in  AW  data address.
- `d_size`  in  3  log2 of the access size in bytes.
- `d_strobe`  in  DW/8  byte write enables; all zero means a load.
- `d_wdata`  in  DW  store data.
- `d_ready`  out  1  data completion pulse; `d_rdata` is valid in the same cycle.
- `d_rdata`  out  DW  load data.
- `m_valid`  out  1  memory request valid (registered).
- `m_addr`  out  AW  latched request address.
- `m_size`  out  3  latched request size.
- `m_strobe`  out  DW/8  latched request strobe.
- `m_wdata`  out  DW  latched store data.
- `m_ready`  in  1  memory completion, single-cycle pulse.
- `m_rdata`  in  DW  memory read data, valid with `m_ready`.
- `gnt_d`  out  1  1 while a data transaction is in flight.
- `busy`  out  1  1 in any state other than IDLE.

## Operation
States:
- **IDLE**: no transaction in flight.
- **BUSY_I**: fetch transaction in flight.
- **BUSY_D**: data transaction in flight.

Arbitration, evaluated in IDLE only:
- If `d_valid && !(i_valid && cnt == STARVE)`, go to BUSY_D.
- Else if `i_valid`, go to BUSY_I.
- Else stay in IDLE.

Fields latched at the grant edge into the `m_*` registers:
- Fetch grant: `m_addr = i_addr`, `m_size = 3'd3`, `m_strobe = 0`, `m_wdata = 0`.
- Data grant: the `d_*` fields are copied unchanged.
- `m_valid` is set at the grant edge and cleared at the completion edge.

Starvation counter `cnt`:
- Width is 4 bits.
- At a data grant with `i_valid = 1`: increments, saturating at `STARVE`.
- At a data grant with `i_valid = 0`: clears to 0.
- At any fetch grant: clears to 0.

Completion:
- In BUSY_x with `m_ready = 1`, the arbiter drives `x_ready = 1` combinationally in the same cycle.
- `i_data` and `d_rdata` are driven directly from `m_rdata` at all times.
- Next state is IDLE.

Requester and memory-side rules:
- A requester holds `valid` and its fields stable until its `ready` pulse. The latched copy makes later changes harmless.
- If a requester drops `valid` while its transaction is in flight, the transaction still completes and the `ready` pulse is still issued.
- `m_ready` while in IDLE is ignored.
- `i_ready` and `d_ready` are never both 1, and each is 0 outside its own BUSY state.
- `gnt_d = (state == BUSY_D)`; `busy = (state != IDLE)`.

Reset (synchronous):
- State returns to IDLE and `cnt` to 0.
- `m_valid`, `m_addr`, `m_size`, `m_strobe` and `m_wdata` all return to 0.
- Reset mid-transaction abandons the transaction with no `ready` pulse. A late `m_ready` arriving after reset is ignored because the arbiter is in IDLE.

## Timing
- Request sampled in IDLE at edge N: `m_valid = 1` from cycle N+1.
- `m_ready` in cycle K: `x_ready` is asserted in cycle K, and state is IDLE at K+1.
- Next grant is taken at the edge ending cycle K+1, so there is one IDLE cycle between back-to-back transactions.
- Minimum transaction: 2 cycles from request to `ready` (grant cycle plus a 0-wait response).
- Latency from `m_ready` to `ready`: 0 cycles (combinational).
- All `m_*` outputs are registers, with no combinational path from any `valid` input.
- When `i_valid` and `d_valid` rise in the same cycle with `cnt < STARVE`, data wins.

## Test plan
- **Fetch alone**: `i_valid = 1`, `i_addr = 0x8000_0000`; memory answers with 0-wait and `m_rdata = 0x13`.
  - Required: `m_valid` in cycle 1 with `m_addr = 0x8000_0000`, `m_strobe = 0`; `i_ready = 1` and `i_data = 0x13` in cycle 1.
- **Simultaneous requests**: both valid; `d_addr = 0x100`, `d_strobe = 0xFF`, `d_wdata = 0xDEAD`.
  - Required: BUSY_D first with `m_wdata = 0xDEAD`; after `d_ready`, one IDLE cycle, then BUSY_I.
- **Starvation**: `i_valid` held high and `d_valid` held high, `STARVE = 4`.
  - Required: grant order D, D, D, D, I, D…; `cnt` reads 4 at the fifth arbitration and 0 after the I grant.
- **Wait states and unstable inputs**: `m_ready` delayed 5 cycles; `d_addr` is changed during the wait.
  - Required: `m_addr` keeps the originally latched value; `d_ready` pulses exactly once, in cycle 6; `i_ready` stays 0 throughout.
- **Reset mid-transaction**: reset asserted in cycle 3 of BUSY_D.
  - Required: at the next edge `m_valid = 0`, `busy = 0`, `cnt = 0`; an `m_ready` pulse one cycle later produces no `d_ready`.
- **Stray response**: `m_ready` pulsed while in IDLE.
  - Required: no `ready` pulse, no state change.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side handshake bundle for the port arbiter
interface mem_port_arbiter_if #(
   parameter int AW = 64,
   parameter int DW = 64
);
   logic i_valid;
   logic [AW-1:0] i_addr;
   logic i_ready;
   logic [DW-1:0] i_data;
   logic d_valid;
   logic [AW-1:0] d_addr;
   logic [2:0] d_size;
   logic [DW/8-1:0] d_strobe;
   logic [DW-1:0] d_wdata;
   logic d_ready;
   logic [DW-1:0] d_rdata;
   logic m_valid;
   logic [AW-1:0] m_addr;
   logic [2:0] m_size;
   logic [DW/8-1:0] m_strobe;
   logic [DW-1:0] m_wdata;
   logic m_ready;
   logic [DW-1:0] m_rdata;
   modport slave (
      input  i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata, m_ready, m_rdata,
      output i_ready, i_data, d_ready, d_rdata, m_valid, m_addr, m_size, m_strobe, m_wdata
   );
   modport master (
      output i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata, m_ready, m_rdata,
      input  i_ready, i_data, d_ready, d_rdata, m_valid, m_addr, m_size, m_strobe, m_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one outstanding memory transaction, data first, fetch protected by a starvation counter
module mem_port_arbiter #(
   parameter int AW = 64,
   parameter int DW = 64,
   parameter int STARVE = 4
) (
   input  logic clk,
   input  logic reset,
   mem_port_arbiter_if.slave bus,
   output logic gnt_d,
   output logic busy
);
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
   localparam logic [3:0] CMAX = 4'(STARVE);
   state_t state, state_nxt;
   logic [3:0] cnt;
   logic win_d;
   always_comb begin
      win_d = bus.d_valid && !(bus.i_valid && cnt == CMAX);
      state_nxt = state == IDLE ? (win_d ? BUSY_D : bus.i_valid ? BUSY_I : IDLE)
                                : (bus.m_ready ? IDLE : state);
   end
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= 4'd0;
         bus.m_valid <= 1'b0;
         bus.m_addr <= AW'(0);
         bus.m_size <= 3'd0;
         bus.m_strobe <= (DW/8)'(0);
         bus.m_wdata <= DW'(0);
      end else if (state == IDLE && win_d) begin
         cnt <= bus.i_valid ? (cnt == CMAX ? cnt : cnt + 4'd1) : 4'd0;
         bus.m_valid <= 1'b1;
         bus.m_addr <= bus.d_addr;
         bus.m_size <= bus.d_size;
         bus.m_strobe <= bus.d_strobe;
         bus.m_wdata <= bus.d_wdata;
      end else if (state == IDLE && bus.i_valid) begin
         cnt <= 4'd0;
         bus.m_valid <= 1'b1;
         bus.m_addr <= bus.i_addr;
         bus.m_size <= 3'd3;
         bus.m_strobe <= (DW/8)'(0);
         bus.m_wdata <= DW'(0);
      end else if (state != IDLE && bus.m_ready) begin
         bus.m_valid <= 1'b0;
      end
   end
   // completion is combinational so the requester sees ready in the same cycle as m_ready
   assign bus.i_ready = state == BUSY_I && bus.m_ready;
   assign bus.d_ready = state == BUSY_D && bus.m_ready;
   assign bus.i_data = bus.m_rdata;
   assign bus.d_rdata = bus.m_rdata;
   assign gnt_d = state == BUSY_D;
   assign busy = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters and memory against a transaction-level arbitration model
module tb_mem_port_arbiter;
   localparam int STARVE = 4;
   localparam int NCYC = 3000;
   localparam int DRAIN = 100;
   typedef struct {
      bit is_d;
      logic [63:0] addr;
      logic [2:0] size;
      logic [7:0] strobe;
      logic [63:0] wdata;
      int cnt;
   } gnt_t;
   typedef struct {
      int who;
      logic [63:0] data;
   } rsp_t;
   logic clk = 0;
   logic reset = 1;
   logic gnt_d, busy;
   int checks = 0;
   int errors = 0;
   gnt_t gq[$];
   rsp_t rq[$];
   bit post_rst = 0;
   bit prev_mv = 0;
   bit mbusy = 0;
   bit i_inflight = 0;
   bit d_inflight = 0;
   bit clr_i = 0;
   bit clr_d = 0;
   bit do_rst;
   int mwho = 0;
   int mcnt = 0;
   int wait_left = 0;
   mem_port_arbiter_if #(.AW(64), .DW(64)) bus ();
   mem_port_arbiter #(.AW(64), .DW(64), .STARVE(STARVE)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .gnt_d(gnt_d),
      .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      gnt_t g;
      rsp_t r;
      if (bus.m_valid === 1'b1 && !prev_mv) begin
         if (gq.size() == 0) chk("unexpected_grant", 64'd1, 64'd0);
         else begin
            g = gq.pop_front();
            chk("gnt_d", 64'(gnt_d), 64'(g.is_d));
            chk("busy_on_grant", 64'(busy), 64'd1);
            chk("m_addr", bus.m_addr, g.addr);
            chk("m_size", 64'(bus.m_size), 64'(g.size));
            chk("m_strobe", 64'(bus.m_strobe), 64'(g.strobe));
            chk("m_wdata", bus.m_wdata, g.wdata);
            chk("cnt", 64'(dut.cnt), 64'(g.cnt));
         end
      end
      prev_mv = bus.m_valid === 1'b1;
      if (bus.m_ready) begin
         if (rq.size() == 0) chk("unexpected_m_ready", 64'd1, 64'd0);
         else begin
            r = rq.pop_front();
            chk("i_ready", 64'(bus.i_ready), 64'(r.who == 1));
            chk("d_ready", 64'(bus.d_ready), 64'(r.who == 2));
            if (r.who == 1) chk("i_data", bus.i_data, r.data);
            if (r.who == 2) chk("d_rdata", bus.d_rdata, r.data);
         end
      end else begin
         chk("i_ready_idle", 64'(bus.i_ready), 64'd0);
         chk("d_ready_idle", 64'(bus.d_ready), 64'd0);
      end
      if (post_rst) begin
         chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_cnt", 64'(dut.cnt), 64'd0);
      end
   end
   initial begin
      bus.i_valid = 0; bus.i_addr = 0;
      bus.d_valid = 0; bus.d_addr = 0; bus.d_size = 0; bus.d_strobe = 0; bus.d_wdata = 0;
      bus.m_ready = 0; bus.m_rdata = 0;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      for (int c = 0; c < NCYC + DRAIN; c++) begin
         bit gen;
         int pr;
         @(posedge clk);
         #1;
         post_rst = reset;
         reset = 0;
         if (clr_i) bus.i_valid = 0;
         if (clr_d) bus.d_valid = 0;
         clr_i = 0;
         clr_d = 0;
         gen = c < NCYC;
         pr = c < 300 ? 1 : 3;
         if (gen && !bus.i_valid && !i_inflight && $urandom % pr == 0) begin
            bus.i_valid = 1;
            bus.i_addr = {$urandom, $urandom};
         end
         if (gen && !bus.d_valid && !d_inflight && $urandom % pr == 0) begin
            bus.d_valid = 1;
            bus.d_addr = {$urandom, $urandom};
            bus.d_size = 3'($urandom % 4);
            bus.d_strobe = $urandom % 2 ? 8'h00 : 8'($urandom);
            bus.d_wdata = {$urandom, $urandom};
         end
         if (i_inflight) begin
            bus.i_addr = {$urandom, $urandom};
            if ($urandom % 8 == 0) bus.i_valid = 0;
         end
         if (d_inflight) begin
            bus.d_addr = {$urandom, $urandom};
            bus.d_wdata = {$urandom, $urandom};
            bus.d_strobe = 8'($urandom);
            if ($urandom % 8 == 0) bus.d_valid = 0;
         end
         do_rst = gen && c > 20 && $urandom % 150 == 0;
         bus.m_ready = 0;
         bus.m_rdata = {$urandom, $urandom};
         if (do_rst) reset = 1;
         else if (mbusy) begin
            if (wait_left == 0) begin
               bus.m_ready = 1;
               rq.push_back('{mwho, bus.m_rdata});
            end else wait_left--;
         end else if (post_rst || $urandom % 6 == 0) begin
            bus.m_ready = 1;
            rq.push_back('{0, bus.m_rdata});
         end
         // what the arbiter must do at the edge ending this cycle
         if (do_rst) begin
            mbusy = 0; mcnt = 0; i_inflight = 0; d_inflight = 0; clr_i = 1; clr_d = 1;
         end else if (mbusy) begin
            if (bus.m_ready) begin
               mbusy = 0;
               if (mwho == 2) begin d_inflight = 0; clr_d = 1; end
               else begin i_inflight = 0; clr_i = 1; end
            end
         end else if (bus.d_valid && !(bus.i_valid && mcnt == STARVE)) begin
            mcnt = bus.i_valid ? (mcnt < STARVE ? mcnt + 1 : STARVE) : 0;
            gq.push_back('{1'b1, bus.d_addr, bus.d_size, bus.d_strobe, bus.d_wdata, mcnt});
            mbusy = 1; mwho = 2; d_inflight = 1; wait_left = $urandom % 6;
         end else if (bus.i_valid) begin
            mcnt = 0;
            gq.push_back('{1'b0, bus.i_addr, 3'd3, 8'h00, 64'd0, 0});
            mbusy = 1; mwho = 1; i_inflight = 1; wait_left = $urandom % 6;
         end
      end
      @(negedge clk);
      chk("grants_left", 64'(gq.size()), 64'd0);
      chk("responses_left", 64'(rq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
